// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single RegisterFile write port between the writeback stage and
//   the multi-cycle mul/div unit. Writeback always owns the port; mul/div
//   results wait in a small circular FIFO and drain into idle port cycles.
//   ID-stage reads that hit a queued, not-yet-written register raise id_stall.
//
//   Optional build macro ARB_FORWARD_EN: instead of stalling, queued data is
//   forwarded to the ID stage on fwd1_*/fwd2_* and id_stall is held 0.
//   Without the macro, fwd* outputs are tied 0.
//
// Ports
//   clock, reset            clock and asynchronous active-high reset
//   wb_reg_write/rt_rd/data writeback write request (always wins)
//   md_valid/rd/data        mul/div result offer; md_ready = FIFO not full
//   read_reg1/2             ID-stage read addresses
//   rf_reg_write/rt_rd/data muxed RegisterFile write port
//   id_stall                read hazard against a live pending entry
//   fwd1_*/fwd2_*           forwarded pending data (ARB_FORWARD_EN only)
module regfile_write_arbiter #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rt_rd,
  input  logic [31:0] wb_write_data,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  output logic        md_ready,
  input  logic [4:0]  read_reg1,
  input  logic [4:0]  read_reg2,
  output logic        rf_reg_write,
  output logic [4:0]  rf_rt_rd,
  output logic [31:0] rf_write_data,
  output logic        id_stall,
  output logic        fwd1_valid,
  output logic [31:0] fwd1_data,
  output logic        fwd2_valid,
  output logic [31:0] fwd2_data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DEPTH-1:0] live_q, live_d;
  logic [4:0]       rd_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic wb_win, not_empty, head_live, push, drain, pop;

  assign wb_win    = wb_reg_write && (wb_rt_rd != 5'd0);
  assign not_empty = (count_q != '0);
  assign head_live = not_empty && live_q[head_q];
  // Registered count only: no path from rf-side inputs to md_ready.
  assign md_ready  = (count_q < CW'(DEPTH));
  // Pushes to r0 are accepted by the handshake but never stored.
  assign push      = md_valid && md_ready && (md_rd != 5'd0);
  assign drain     = head_live && !wb_win;
  // A squashed head is discarded on the next edge whatever WB is doing.
  assign pop       = not_empty && (!live_q[head_q] || drain);

  // Write-port mux
  always_comb begin
    rf_reg_write  = 1'b0;
    rf_rt_rd      = 5'd0;
    rf_write_data = 32'd0;
    if (wb_win) begin
      rf_reg_write  = 1'b1;
      rf_rt_rd      = wb_rt_rd;
      rf_write_data = wb_write_data;
    end else if (head_live) begin
      rf_reg_write  = 1'b1;
      rf_rt_rd      = rd_q[head_q];
      rf_write_data = data_q[head_q];
    end
  end

  // Next state. Squash is applied before the push so an entry written on the
  // same edge as a WB write to the same register stays live (it is newer).
  always_comb begin
    live_d = live_q;
    if (wb_win) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (rd_q[i] == wb_rt_rd) live_d[i] = 1'b0;
      end
    end
    // Freed slots are kept non-live so hazard checks only see queued entries.
    if (pop)  live_d[head_q] = 1'b0;
    if (push) live_d[tail_q] = 1'b1;
    head_d  = pop  ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      live_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      live_q  <= live_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload is qualified by live_q, so it needs no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      rd_q[tail_q]   <= md_rd;
      data_q[tail_q] <= md_data;
    end
  end

  // Hazard / forward lookup, oldest to newest so the newest match wins.
  logic          hit1, hit2;
  logic [PW-1:0] idx;
`ifdef ARB_FORWARD_EN
  logic [31:0]   hdata1, hdata2;
`endif

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    idx  = '0;
`ifdef ARB_FORWARD_EN
    hdata1 = 32'd0;
    hdata2 = 32'd0;
`endif
    for (int i = 0; i < int'(DEPTH); i++) begin
      idx = head_q + PW'(i);
      if (live_q[idx] && (read_reg1 != 5'd0) && (rd_q[idx] == read_reg1)) begin
        hit1 = 1'b1;
`ifdef ARB_FORWARD_EN
        hdata1 = data_q[idx];
`endif
      end
      if (live_q[idx] && (read_reg2 != 5'd0) && (rd_q[idx] == read_reg2)) begin
        hit2 = 1'b1;
`ifdef ARB_FORWARD_EN
        hdata2 = data_q[idx];
`endif
      end
    end
  end

`ifdef ARB_FORWARD_EN
  assign id_stall   = 1'b0;
  assign fwd1_valid = hit1;
  assign fwd1_data  = hdata1;
  assign fwd2_valid = hit2;
  assign fwd2_data  = hdata2;
`else
  assign id_stall   = hit1 | hit2;
  assign fwd1_valid = 1'b0;
  assign fwd1_data  = 32'd0;
  assign fwd2_valid = 1'b0;
  assign fwd2_data  = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  localparam int unsigned DEPTH = 2;

  logic        clock, reset;
  logic        wb_reg_write;
  logic [4:0]  wb_rt_rd;
  logic [31:0] wb_write_data;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  logic [4:0]  read_reg1, read_reg2;
  logic        rf_reg_write;
  logic [4:0]  rf_rt_rd;
  logic [31:0] rf_write_data;
  logic        id_stall;
  logic        fwd1_valid, fwd2_valid;
  logic [31:0] fwd1_data, fwd2_data;

  regfile_write_arbiter #(.DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .wb_reg_write  (wb_reg_write),
    .wb_rt_rd      (wb_rt_rd),
    .wb_write_data (wb_write_data),
    .md_valid      (md_valid),
    .md_rd         (md_rd),
    .md_data       (md_data),
    .md_ready      (md_ready),
    .read_reg1     (read_reg1),
    .read_reg2     (read_reg2),
    .rf_reg_write  (rf_reg_write),
    .rf_rt_rd      (rf_rt_rd),
    .rf_write_data (rf_write_data),
    .id_stall      (id_stall),
    .fwd1_valid    (fwd1_valid),
    .fwd1_data     (fwd1_data),
    .fwd2_valid    (fwd2_valid),
    .fwd2_data     (fwd2_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard: pending mul/div writes in arrival order, with squash state.
  typedef struct {
    bit          live;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;
  ent_t mq[$];

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare all outputs at the negedge against the scoreboard, then advance
  // the scoreboard to what the coming rising edge should do.
  task automatic tick();
    bit          wb_win, exp_ready, exp_we, h1, h2;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data, d1, d2;
    @(negedge clock);
    if (reset) mq.delete();
    wb_win    = wb_reg_write && (wb_rt_rd != 5'd0);
    exp_ready = (mq.size() < int'(DEPTH));
    exp_we = 1'b0; exp_rd = 5'd0; exp_data = 32'd0;
    if (wb_win) begin
      exp_we = 1'b1; exp_rd = wb_rt_rd; exp_data = wb_write_data;
    end else if (mq.size() > 0 && mq[0].live) begin
      exp_we = 1'b1; exp_rd = mq[0].rd; exp_data = mq[0].data;
    end
    h1 = 1'b0; h2 = 1'b0; d1 = 32'd0; d2 = 32'd0;
    foreach (mq[i]) begin
      if (mq[i].live && read_reg1 != 5'd0 && mq[i].rd == read_reg1) begin
        h1 = 1'b1; d1 = mq[i].data;
      end
      if (mq[i].live && read_reg2 != 5'd0 && mq[i].rd == read_reg2) begin
        h2 = 1'b1; d2 = mq[i].data;
      end
    end
    check("md_ready", 32'(md_ready), 32'(exp_ready));
    check("rf_reg_write", 32'(rf_reg_write), 32'(exp_we));
    check("rf_rt_rd", 32'(rf_rt_rd), 32'(exp_rd));
    check("rf_write_data", rf_write_data, exp_data);
`ifdef ARB_FORWARD_EN
    check("id_stall", 32'(id_stall), 32'd0);
    check("fwd1_valid", 32'(fwd1_valid), 32'(h1));
    check("fwd1_data", fwd1_data, d1);
    check("fwd2_valid", 32'(fwd2_valid), 32'(h2));
    check("fwd2_data", fwd2_data, d2);
`else
    check("id_stall", 32'(id_stall), 32'(h1 | h2));
    check("fwd1_valid", 32'(fwd1_valid), 32'd0);
    check("fwd1_data", fwd1_data, 32'd0);
    check("fwd2_valid", 32'(fwd2_valid), 32'd0);
    check("fwd2_data", fwd2_data, 32'd0);
`endif
    if (!reset) begin
      if (mq.size() > 0 && (!mq[0].live || !wb_win)) void'(mq.pop_front());
      if (wb_win) begin
        foreach (mq[i]) if (mq[i].rd == wb_rt_rd) mq[i].live = 1'b0;
      end
      if (md_valid && exp_ready && md_rd != 5'd0) mq.push_back('{1'b1, md_rd, md_data});
    end
    @(posedge clock);
    #1;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] rd, input logic [31:0] d);
    wb_reg_write = en; wb_rt_rd = rd; wb_write_data = d;
  endtask

  task automatic set_md(input logic v, input logic [4:0] rd, input logic [31:0] d);
    md_valid = v; md_rd = rd; md_data = d;
  endtask

  initial begin
    reset = 1'b1;
    set_wb(1'b0, 5'd0, 32'd0);
    set_md(1'b1, 5'd3, 32'd500);
    read_reg1 = 5'd3; read_reg2 = 5'd0;

    // Reset held with md_valid asserted: nothing may be queued.
    tick();
    tick();
    reset = 1'b0;
    set_md(1'b0, 5'd0, 32'd0);
    tick();

    // Single push, drain next cycle; read_reg1=3 stalls/forwards until drained.
    set_md(1'b1, 5'd3, 32'd500);
    tick();
    set_md(1'b0, 5'd0, 32'd0);
    tick();
    tick();

    // WB owns the port; md result waits until WB goes idle.
    read_reg1 = 5'd6; read_reg2 = 5'd5;
    set_wb(1'b1, 5'd5, 32'd7);
    set_md(1'b1, 5'd6, 32'd9);
    tick();
    set_md(1'b0, 5'd0, 32'd0);
    repeat (3) tick();
    set_wb(1'b0, 5'd0, 32'd0);
    tick();
    tick();

    // Fill the FIFO under WB; third offer must be refused.
    read_reg1 = 5'd8; read_reg2 = 5'd9;
    set_wb(1'b1, 5'd5, 32'd7);
    set_md(1'b1, 5'd8, 32'd11);
    tick();
    set_md(1'b1, 5'd9, 32'd12);
    tick();
    set_md(1'b1, 5'd10, 32'd13);
    tick();
    set_md(1'b0, 5'd0, 32'd0);
    set_wb(1'b0, 5'd0, 32'd0);
    repeat (3) tick();

    // Squash: queued reg4=100 is superseded by WB reg4=200 and never written.
    read_reg1 = 5'd4; read_reg2 = 5'd0;
    set_wb(1'b1, 5'd7, 32'd1);
    set_md(1'b1, 5'd4, 32'd100);
    tick();
    set_md(1'b0, 5'd0, 32'd0);
    set_wb(1'b1, 5'd4, 32'd200);
    tick();
    set_wb(1'b0, 5'd0, 32'd0);
    repeat (2) tick();

    // Same-edge push and WB write to one register: pushed entry stays live.
    set_wb(1'b1, 5'd4, 32'd300);
    set_md(1'b1, 5'd4, 32'd400);
    tick();
    set_md(1'b0, 5'd0, 32'd0);
    set_wb(1'b0, 5'd0, 32'd0);
    repeat (2) tick();

    // Push to r0 is accepted and dropped; r0 reads never stall.
    read_reg1 = 5'd0;
    set_md(1'b1, 5'd0, 32'd500);
    tick();
    set_md(1'b0, 5'd0, 32'd0);
    repeat (2) tick();

    // Asynchronous reset with two entries queued.
    read_reg1 = 5'd8; read_reg2 = 5'd9;
    set_wb(1'b1, 5'd5, 32'd7);
    set_md(1'b1, 5'd8, 32'd21);
    tick();
    set_md(1'b1, 5'd9, 32'd22);
    tick();
    set_md(1'b0, 5'd0, 32'd0);
    set_wb(1'b0, 5'd0, 32'd0);
    #2 reset = 1'b1;
    #1;
    mq.delete();
    check("async_rst_md_ready", 32'(md_ready), 32'd1);
    check("async_rst_rf_reg_write", 32'(rf_reg_write), 32'd0);
    check("async_rst_id_stall", 32'(id_stall), 32'd0);
    check("async_rst_fwd1_valid", 32'(fwd1_valid), 32'd0);
    tick();
    reset = 1'b0;
    repeat (3) tick();

    // Random traffic over a small register range to exercise squash/forward.
    for (int n = 0; n < 200; n++) begin
      set_wb(($urandom % 3) == 0, 5'($urandom_range(0, 4)), $urandom);
      set_md(($urandom % 2) == 0, 5'($urandom_range(0, 4)), $urandom);
      read_reg1 = 5'($urandom_range(0, 4));
      read_reg2 = 5'($urandom_range(0, 4));
      tick();
    end
    set_wb(1'b0, 5'd0, 32'd0);
    set_md(1'b0, 5'd0, 32'd0);
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single RegisterFile write port between the pipeline writeback stage and the multi-cycle multiply/divide unit.
- The writeback stage always wins the port. Multi-cycle results are queued in a small FIFO and drained into idle port cycles.
- Flags ID-stage reads that hit a queued, not-yet-written register, so decode stalls instead of reading stale data.
- Sits between the WB stage, the mul/div unit and the RegisterFile write inputs.

Parameters:
- DEPTH, 2, number of pending-write FIFO entries (power of two, >=2).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- wb_reg_write  in  1  writeback stage write enable.
- wb_rt_rd  in  5  writeback destination register.
- wb_write_data  in  32  writeback data.
- md_valid  in  1  mul/div result offered.
- md_rd  in  5  mul/div destination register.
- md_data  in  32  mul/div result.
- md_ready  out  1  FIFO can accept; md_valid&&md_ready = push.
- read_reg1  in  5  ID read address 1.
- read_reg2  in  5  ID read address 2.
- rf_reg_write  out  1  to RegisterFile wb_reg_write.
- rf_rt_rd  out  5  to RegisterFile wb_rt_rd.
- rf_write_data  out  32  to RegisterFile wb_write_data.
- id_stall  out  1  read hazard against a pending entry.
- fwd1_valid  out  1  forward hit for read_reg1 (ARB_FORWARD_EN only, else 0).
- fwd1_data  out  32  forwarded data for read_reg1 (else 0).
- fwd2_valid  out  1  forward hit for read_reg2 (else 0).
- fwd2_data  out  32  forwarded data for read_reg2 (else 0).

Behaviour:
- State:
  - Circular FIFO of DEPTH entries, each {live, rd[4:0], data[31:0]}.
  - Head/tail pointers and count; count is log2(DEPTH)+1 bits.
- Reset (async, any time, including mid-drain): count=0, pointers=0, all live=0, pending entries discarded. Outputs then read rf_reg_write=0, md_ready=1, id_stall=0, fwd*=0.
- md_ready = (count < DEPTH), driven from registered count only. No combinational path from rf-side inputs.
- Push, on an edge with md_valid&&md_ready:
  - md_rd!=0: write {live=1, md_rd, md_data} at tail; tail wraps modulo DEPTH.
  - md_rd==0: accepted and dropped; count unchanged.
- Write-port mux (combinational, same cycle):
  - wb_reg_write && wb_rt_rd!=0: rf_* = wb_*, zero latency.
  - Otherwise, count>0 and head live: rf_* = head entry, rf_reg_write=1, pop on the edge.
  - Otherwise rf_reg_write=0, rf_rt_rd=0, rf_write_data=0.
- Squashed head (live=0): popped on the next edge regardless of WB activity. It never drives the port.
- Squash: on an edge with wb_reg_write && wb_rt_rd=R!=0, every queued entry with rd==R gets live=0. WB is the newer writer.
  - Exception: an entry pushed on that same edge is the newer writer and stays live.
- Push and pop on the same edge: count unchanged, both pointers advance.
- Minimum md-to-RF latency: 1 cycle (push edge, then drain on the next idle-port edge).
- id_stall = any live entry with rd==read_reg1 (read_reg1!=0), or with rd==read_reg2 (read_reg2!=0). Combinational.
- Register 0 never stalls, never forwards and is never written.

Optional Feature:
- ARB_FORWARD_EN defined:
  - fwdN_valid/fwdN_data return the newest live entry whose rd matches read_regN (nearest tail wins).
  - id_stall is held 0.
- ARB_FORWARD_EN undefined: fwd* tied 0; stall behaviour as above.

Test Plan:
- Reset with md_valid=1 queued -> md_ready=1, rf_reg_write=0, id_stall=0. Push md_rd=3, data 500 with WB idle -> next cycle rf_reg_write=1, rf_rt_rd=3, rf_write_data=500; count returns to 0.
- WB writes reg 5 = 7 every cycle; push md reg 6 = 9 -> rf_* shows only reg 5 while WB is active. Drop WB -> reg 6 = 9 written the next cycle.
- Push md reg 8 = 11 and reg 9 = 12 under continuous WB -> md_ready=0 at count 2; third md_valid not accepted. WB idle -> drain in order 8, then 9; md_ready back to 1.
- Queue reg 4 = 100, then WB writes reg 4 = 200 -> entry squashed; reg 4 reads 200 afterwards, and 100 is never written.
- Queue reg 3 = 500, read_reg1=3, read_reg2=0 -> id_stall=1, clearing the cycle after the drain. With ARB_FORWARD_EN: id_stall=0, fwd1_valid=1, fwd1_data=500, fwd2_valid=0.
- md push to reg 0 with data 500 -> accepted, count stays 0, no RF write. Assert reset mid-queue with 2 entries -> count=0, no write of the discarded entries.
